// File: rtl/gate_sweep_checker.sv
// Sweeps all 8 input combinations of a 3-input gate, samples its synchronized
// output after a settle window, and checks the MSB-first truth-table word.
module gate_sweep_checker #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          SAMPLES       = 4,
  parameter logic [7:0]  EXPECTED      = 8'h61
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_word,
  output logic       pass,
  output logic [7:0] unstable
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LD  = 8'(SETTLE_CYCLES);
  localparam logic [3:0] SAMPLES_LD = 4'(SAMPLES);

  state_t     state;
  logic [2:0] idx;
  logic [7:0] settle_cnt;
  logic [3:0] samp_cnt;
  logic [7:0] shadow_word, shadow_unstable;
  logic [7:0] word_nxt, unst_nxt;
  logic [2:0] pos;
  logic       dut_meta, dut_sync;

  // idx is held at 0 outside a sweep, so it doubles as the driver register
  assign {drv_in1, drv_in2, drv_in3} = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_meta <= 1'b0;
      dut_sync <= 1'b0;
    end else begin
      dut_meta <= dut_out;
      dut_sync <= dut_meta;
    end
  end

  // Shadow update including the sample taken this cycle
  always_comb begin
    pos      = 3'd7 - idx;
    word_nxt = shadow_word;
    unst_nxt = shadow_unstable;
    if (samp_cnt == SAMPLES_LD)
      word_nxt[pos] = dut_sync;
    else if (dut_sync != shadow_word[pos])
      unst_nxt[pos] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 3'd0;
      settle_cnt      <= 8'd0;
      samp_cnt        <= 4'd0;
      shadow_word     <= 8'h00;
      shadow_unstable <= 8'h00;
      busy            <= 1'b0;
      done            <= 1'b0;
      truth_word      <= 8'h00;
      unstable        <= 8'h00;
      pass            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state           <= SETTLE;
            idx             <= 3'd0;
            settle_cnt      <= SETTLE_LD;
            shadow_word     <= 8'h00;
            shadow_unstable <= 8'h00;
            busy            <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            idx   <= 3'd0;
            busy  <= 1'b0;
          end else if (settle_cnt == 8'd1) begin
            state    <= SAMPLE;
            samp_cnt <= SAMPLES_LD;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            idx   <= 3'd0;
            busy  <= 1'b0;
          end else begin
            shadow_word     <= word_nxt;
            shadow_unstable <= unst_nxt;
            if (samp_cnt == 4'd1) begin
              if (idx == 3'd7) begin
                // Publish on entry to DONE so results are valid alongside the done pulse
                state      <= DONE;
                idx        <= 3'd0;
                busy       <= 1'b0;
                done       <= 1'b1;
                truth_word <= word_nxt;
                unstable   <= unst_nxt;
                pass       <= (word_nxt == EXPECTED);
              end else begin
                state      <= SETTLE;
                idx        <= idx + 3'd1;
                settle_cnt <= SETTLE_LD;
              end
            end else begin
              samp_cnt <= samp_cnt - 4'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a 3-cycle-delay gate defined by its truth table,
// directed and random sweeps checked against the table-derived expected result.
module tb_gate_sweep_checker;

  localparam int PER = 20;   // SETTLE_CYCLES + SAMPLES at default parameters

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       drv_in1, drv_in2, drv_in3;
  logic       dut_out, busy, done, pass;
  logic [7:0] truth_word, unstable;
  logic [2:0] drv;
  logic [7:0] tbl;
  logic [2:0] g_pipe;
  logic       ovr_en, ovr_val;
  int         done_cnt = 0;
  int         errors = 0;
  int         checks = 0;

  gate_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3),
    .dut_out(dut_out), .busy(busy), .done(done),
    .truth_word(truth_word), .pass(pass), .unstable(unstable)
  );

  always #5 clk = ~clk;

  assign drv = {drv_in1, drv_in2, drv_in3};

  // Gate model: output for index idx is tbl[7-idx], seen 3 clocks later
  always @(posedge clk) g_pipe <= {g_pipe[1:0], tbl[3'd7 - drv]};
  assign dut_out = ovr_en ? ovr_val : g_pipe[2];

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_drv"}, drv, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_truth"}, truth_word, 0);
    chk({tag, "_unstable"}, unstable, 0);
    chk({tag, "_pass"}, pass, 0);
  endtask

  // Full sweep of gate table t. tog5 forces a 1 for the first idx-5 sample and
  // toggles afterwards; busy_starts pulses start while the sweep is running.
  task automatic sweep(input logic [7:0] t, input bit tog5, input bit busy_starts);
    logic [7:0] ew, eu;
    int k, dc0;
    tbl = t;
    ew  = t;
    eu  = 8'h00;
    if (tog5) begin
      ew[7-5] = 1'b1;
      eu[7-5] = 1'b1;
    end
    dc0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_drv", drv, 0);
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      if (k < 8*PER && (k % PER == 0 || k % PER == PER-1))
        chk("drv_idx", drv, k / PER);
      if (tog5 && k >= 5*PER && k <= 114) begin
        ovr_en = 1'b1; ovr_val = 1'b1;
      end else if (tog5 && k >= 115 && k <= 121) begin
        ovr_en = 1'b1; ovr_val = (k % 2 == 0);
      end else begin
        ovr_en = 1'b0;
      end
      start = busy_starts && (k == 30 || k == 99);
      step();
      k++;
    end
    ovr_en = 1'b0;
    start  = 1'b0;
    chk("done_cycle", k, 8*PER);
    chk("truth_word", truth_word, ew);
    chk("unstable", unstable, eu);
    chk("pass", pass, ew == 8'h61);
    chk("done_busy", busy, 0);
    chk("done_drv", drv, 0);
    step();
    chk("done_width", done, 0);
    chk("dones_per_sweep", done_cnt - dc0, 1);
  endtask

  initial begin
    int k, dc0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ovr_en = 1'b0; ovr_val = 1'b0; tbl = 8'h61;
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (4) step();

    // Basic 0x61 gate, with ignored start pulses while busy
    sweep(8'h61, 1'b0, 1'b1);
    repeat (5) step();
    chk("busy_starts_idle", busy, 0);
    sweep(8'h00, 1'b0, 1'b0);
    sweep(8'hF0, 1'b0, 1'b0);
    sweep(8'h61, 1'b0, 1'b0);

    // Abort during idx 3 settle
    start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 3*PER + 3; k++) step();
    chk("pre_abort_drv", drv, 3);
    dc0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_drv", drv, 0);
    chk("abort_busy", busy, 0);
    chk("abort_truth", truth_word, 8'h61);
    chk("abort_pass", pass, 1);
    repeat (200) step();
    chk("abort_no_done", done_cnt - dc0, 0);

    // start and abort together in IDLE
    dc0 = done_cnt;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_drv", drv, 0);
    repeat (200) step();
    chk("start_abort_no_done", done_cnt - dc0, 0);

    // Random gate tables
    for (int r = 0; r < 4; r++) begin
      sweep(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 5)) step();
    end

    // Unstable output during idx 5 sampling
    sweep(8'h61, 1'b1, 1'b0);

    // Async reset mid-sweep at idx 6
    tbl = 8'h61;
    start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 6*PER + 5; k++) step();
    chk("pre_reset_drv", drv, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midsweep_reset");
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_reset_done_absent", done, 0);
    sweep(8'h61, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
